// File: rtl/ibex_mem_pkg.sv
// Shared types and helpers for the pipelined Ibex-style memory responder.
// Response payloads are carried at the full bus width BUS_DW.
package ibex_mem_pkg;

  localparam int BUS_DW = 32;
  localparam int BUS_AW = 32;
  localparam int BUS_BW = BUS_DW / 8;
  localparam int LAT_W  = 8;

  typedef struct packed {
    logic [BUS_DW-1:0] rdata;
    logic              err;
    logic [LAT_W-1:0]  age;
  } resp_entry_t;

  // Replace only the bytes of old_word whose byte-enable bit is set.
  function automatic logic [BUS_DW-1:0] be_merge(
    input logic [BUS_DW-1:0] old_word,
    input logic [BUS_DW-1:0] new_word,
    input logic [BUS_BW-1:0] be
  );
    logic [BUS_DW-1:0] merged;
    merged = old_word;
    for (int b = 0; b < BUS_BW; b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ibex_mem_resp_fifo.sv
// In-order response queue with per-entry age counters.
// The head is ready once it has aged LAT-1 cycles past its grant cycle.
module ibex_mem_resp_fifo
  import ibex_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  resp_entry_t                push_entry,
  input  logic                       pop,
  output logic [BUS_DW-1:0]          head_rdata,
  output logic                       head_err,
  output logic                       head_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  resp_entry_t       mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= next_ptr(rd_ptr);
      end
      if (push) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= next_ptr(wr_ptr);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload needs no reset; valid_q decides which slots are live. The pushed
  // age advances by one on entry because the grant cycle itself counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (mem_q[i].age < LAT_W'(LAT))) begin
        mem_q[i].age <= mem_q[i].age + 1'b1;
      end
    end
    if (push) begin
      mem_q[wr_ptr] <= '{rdata: push_entry.rdata,
                         err:   push_entry.err,
                         age:   push_entry.age + 1'b1};
    end
  end

  assign head_rdata = mem_q[rd_ptr].rdata;
  assign head_err   = mem_q[rd_ptr].err;
  assign head_ready = valid_q[rd_ptr] && (mem_q[rd_ptr].age == LAT_W'(LAT - 1));
  assign count      = count_q;

  assert property (@(posedge clk) disable iff (reset) pop |-> valid_q[rd_ptr]);
  assert property (@(posedge clk) disable iff (reset) push |-> (count_q < CNT_W'(DEPTH)));

endmodule

// File: rtl/ibex_mem_pipe_responder.sv
// Memory slave for the Ibex req/gnt/rvalid bus: fixed-latency, in-order
// responses, byte-enable writes, decode errors and stall-driven backpressure.
module ibex_mem_pipe_responder
  import ibex_mem_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_WORDS       = 1024,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RESP_LATENCY    = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 request,
  output logic                                 grant,
  input  logic [ADDR_WIDTH-1:0]                addr,
  input  logic                                 we,
  input  logic [DATA_WIDTH/8-1:0]              be,
  input  logic [DATA_WIDTH-1:0]                wdata,
  input  logic                                 stall,
  output logic                                 rvalid,
  output logic [DATA_WIDTH-1:0]                rdata,
  output logic                                 err,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(BE_W);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;
  localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  // With a latency of one the response leaves straight from the grant cycle.
  localparam bit BYPASS = (RESP_LATENCY == 1);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [IDX_W-1:0]  word_idx;
  logic [MEM_AW-1:0] mem_addr;
  logic              dec_err;
  logic [DATA_WIDTH-1:0] rd_word;
  resp_entry_t       new_entry;

  logic              fifo_push;
  logic              head_ready;
  logic [BUS_DW-1:0] head_rdata;
  logic              head_err;
  logic [CNT_W-1:0]  fifo_count;

  logic              resp_valid;
  logic [BUS_DW-1:0] resp_rdata;
  logic              resp_err;

  // Handshake: a request is accepted in any cycle where request && grant;
  // exactly one rvalid cycle follows RESP_LATENCY cycles later, in order.
  // Requests may be withdrawn before they are granted.
  assign grant = request && !stall && !reset &&
                 (fifo_count < CNT_W'(MAX_OUTSTANDING));

  assign word_idx = IDX_W'(addr >> OFF_W);
  assign dec_err  = (64'(word_idx) >= 64'(MEM_WORDS));
  assign mem_addr = MEM_AW'(word_idx);
  assign rd_word  = mem[mem_addr];

  always_comb begin
    new_entry       = '0;
    new_entry.err   = dec_err;
    new_entry.age   = '0;
    new_entry.rdata = (we || dec_err) ? '0 : BUS_DW'(rd_word);
  end

  always_ff @(posedge clk) begin
    if (grant && we && !dec_err) begin
      mem[mem_addr] <= DATA_WIDTH'(be_merge(BUS_DW'(mem[mem_addr]),
                                            BUS_DW'(wdata),
                                            BUS_BW'(be)));
    end
  end

  assign fifo_push = grant && !BYPASS;

  ibex_mem_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .LAT   (RESP_LATENCY)
  ) u_resp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (new_entry),
    .pop        (head_ready),
    .head_rdata (head_rdata),
    .head_err   (head_err),
    .head_ready (head_ready),
    .count      (fifo_count)
  );

  always_comb begin
    resp_valid = head_ready;
    resp_rdata = head_rdata;
    resp_err   = head_err;
    if (BYPASS) begin
      resp_valid = grant;
      resp_rdata = new_entry.rdata;
      resp_err   = new_entry.err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= resp_valid;
      rdata  <= resp_valid ? DATA_WIDTH'(resp_rdata) : '0;
      err    <= resp_valid && resp_err;
    end
  end

  assign outstanding = fifo_count;

  assert property (@(posedge clk) disable iff (reset)
                   grant |-> (fifo_count != CNT_W'(MAX_OUTSTANDING)));

endmodule

// File: tb/tb_ibex_mem_pipe_responder.sv
// Bench for ibex_mem_pipe_responder: cycle-level queue model plus directed
// literal expectations and a second instance with a long latency.
module tb_ibex_mem_pipe_responder;

  localparam int DW  = 32;
  localparam int MW  = 1024;
  localparam int MO  = 4;
  localparam int LAT = 2;

  localparam int LK_NONE  = 0;
  localparam int LK_RV    = 1;
  localparam int LK_G0    = 2;
  localparam int LK_G1    = 3;
  localparam int LK_QUIET = 4;

  logic        clk = 1'b0;
  logic        reset, request, we, stall;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        grant, rvalid, err;
  logic [31:0] rdata;
  logic [2:0]  outstanding;

  logic        s_reset, s_request;
  logic        s_grant, s_rvalid, s_err;
  logic [31:0] s_rdata;
  logic [2:0]  s_outstanding;

  always #5 clk = ~clk;

  ibex_mem_pipe_responder dut (
    .clk(clk), .reset(reset), .request(request), .grant(grant), .addr(addr),
    .we(we), .be(be), .wdata(wdata), .stall(stall), .rvalid(rvalid),
    .rdata(rdata), .err(err), .outstanding(outstanding)
  );

  ibex_mem_pipe_responder #(.RESP_LATENCY(6)) dut_sat (
    .clk(clk), .reset(s_reset), .request(s_request), .grant(s_grant),
    .addr(32'h0), .we(1'b0), .be(4'h0), .wdata(32'h0), .stall(1'b0),
    .rvalid(s_rvalid), .rdata(s_rdata), .err(s_err), .outstanding(s_outstanding)
  );

  // Bench-side control
  logic        chk_en = 1'b0;
  logic        sat_go = 1'b0;
  int          lit_kind = LK_NONE;
  logic [31:0] lit_data = '0;
  logic        lit_err = 1'b0;

  // Model state, owned by the compare process
  bit   [7:0]      mem_m [MW][4];
  bit   [3:0]      wr_m  [MW];
  int              due_q [$];
  logic [DW+1:0]   exp_q [$];
  int              cyc = 0;
  int              sat_k = 0;
  int              checks = 0;
  int              failures = 0;

  logic [7:0] sat_grant_tbl  = 8'b1111_0011;
  logic [7:0] sat_rvalid_tbl = 8'b0000_0011;
  int         sat_out_tbl [8] = '{0, 1, 2, 3, 4, 4, 3, 3};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int unsigned   idx;
    int            n_out;
    logic          exp_grant;
    logic          e_err;
    logic          known;
    logic [DW-1:0] data;
    logic [DW+1:0] e;
    if (chk_en) begin
      n_out = 0;
      foreach (due_q[i]) if (due_q[i] > cyc) n_out++;
      exp_grant = request && !stall && !reset && (n_out < MO);
      chk("grant", 64'(grant), 64'(exp_grant));
      chk("outstanding", 64'(outstanding), 64'(n_out));
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        chk("rvalid", 64'(rvalid), 64'd1);
        chk("err", 64'(err), 64'(e[DW]));
        if (e[DW+1]) chk("rdata", 64'(rdata), 64'(e[DW-1:0]));
      end else begin
        chk("rvalid_idle", 64'(rvalid), 64'd0);
      end

      case (lit_kind)
        LK_RV: begin
          chk("lit_rvalid", 64'(rvalid), 64'd1);
          chk("lit_rdata", 64'(rdata), 64'(lit_data));
          chk("lit_err", 64'(err), 64'(lit_err));
        end
        LK_G0:    chk("lit_grant0", 64'(grant), 64'd0);
        LK_G1:    chk("lit_grant1", 64'(grant), 64'd1);
        LK_QUIET: begin
          chk("lit_quiet_rvalid", 64'(rvalid), 64'd0);
          chk("lit_quiet_outstanding", 64'(outstanding), 64'd0);
        end
        default: ;
      endcase

      if (sat_go && sat_k < 8) begin
        chk("sat_grant", 64'(s_grant), 64'(sat_grant_tbl[7-sat_k]));
        chk("sat_outstanding", 64'(s_outstanding), 64'(sat_out_tbl[sat_k]));
        chk("sat_rvalid", 64'(s_rvalid), 64'(sat_rvalid_tbl[7-sat_k]));
        sat_k++;
      end

      // Advance the model to the state after this cycle's posedge.
      if (reset) begin
        due_q.delete();
        exp_q.delete();
      end else if (exp_grant) begin
        idx   = addr >> 2;
        e_err = (idx >= MW);
        known = 1'b1;
        data  = '0;
        if (we) begin
          if (!e_err) begin
            for (int b = 0; b < 4; b++) begin
              if (be[b]) begin
                mem_m[idx][b] = wdata[8*b +: 8];
                wr_m[idx][b]  = 1'b1;
              end
            end
          end
        end else if (!e_err) begin
          known = (wr_m[idx] == 4'hF);
          data  = {mem_m[idx][3], mem_m[idx][2], mem_m[idx][1], mem_m[idx][0]};
        end
        due_q.push_back(cyc + LAT);
        exp_q.push_back({known, e_err, data});
      end
    end
    cyc++;
  end

  task automatic drive(input logic rq, input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] d,
                       input logic st, input logic rs);
    request = rq; addr = a; we = w; be = b; wdata = d; stall = st; reset = rs;
    @(posedge clk);
    #1;
    lit_kind = LK_NONE;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a);
    drive(1'b1, a, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    drive(1'b1, a, 1'b1, b, d, 1'b0, 1'b0);
  endtask

  task automatic expect_rv(input logic [31:0] d, input logic e);
    lit_kind = LK_RV; lit_data = d; lit_err = e;
    idle();
  endtask

  initial begin
    reset = 1'b1; request = 1'b0; addr = '0; we = 1'b0; be = '0;
    wdata = '0; stall = 1'b0;
    s_reset = 1'b1; s_request = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    lit_kind = LK_QUIET;
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
    s_reset = 1'b0;

    // Full write then read back after the fixed latency
    lit_kind = LK_G1;
    wr(32'h10, 4'hF, 32'hDEADBEEF);
    rd(32'h10);
    idle();
    expect_rv(32'hDEADBEEF, 1'b0);

    // Partial byte-enable overwrite
    wr(32'h10, 4'h3, 32'h0000CAFE);
    rd(32'h10);
    idle();
    expect_rv(32'hDEADCAFE, 1'b0);

    // Out-of-range read errors; out-of-range write must not alias word 0
    wr(32'h0, 4'hF, 32'h12345678);
    lit_kind = LK_G1;
    rd(32'h1000);
    idle();
    expect_rv(32'h0, 1'b1);
    lit_kind = LK_G1;
    wr(32'h1000, 4'hF, 32'hA5A5A5A5);
    rd(32'h0);
    idle();
    expect_rv(32'h12345678, 1'b0);

    // Stall holds grant low; grant returns the cycle stall drops
    for (int i = 0; i < 5; i++) begin
      lit_kind = LK_G0;
      drive(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    end
    lit_kind = LK_G1;
    rd(32'h10);
    idle(); idle(); idle();

    // Reset with reads in flight drops them; memory survives
    rd(32'h10);
    rd(32'h14);
    rd(32'h18);
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      lit_kind = LK_QUIET;
      idle();
    end
    rd(32'h10);
    idle();
    expect_rv(32'hDEADCAFE, 1'b0);

    // Saturation on the long-latency instance
    s_request = 1'b1;
    sat_go = 1'b1;
    for (int i = 0; i < 8; i++) idle();
    s_request = 1'b0;
    idle(); idle();

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 19) == 0)
        a = ((32'd1024 + 32'($urandom_range(0, 100))) << 2) | 32'($urandom_range(0, 3));
      else
        a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      drive($urandom_range(0, 3) != 0, a, $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0);
    end
    for (int i = 0; i < 10; i++) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
